// File: rtl/alu_arbiter.sv
// rtl/alu_arbiter.sv - round-robin arbiter sharing one data-processing ALU between DP and MEM ports
// Owns the NZCV flags register and evaluates DP condition codes against it.
`ifndef BIT_WIDTH
`define BIT_WIDTH 32
`endif
`ifndef DATAOP_SUB
`define DATAOP_SUB 4'h2
`endif
`ifndef DATAOP_ADD
`define DATAOP_ADD 4'h4
`endif
`ifndef DATAOP_TST
`define DATAOP_TST 4'h8
`endif
`ifndef DATAOP_TEQ
`define DATAOP_TEQ 4'h9
`endif
`ifndef DATAOP_CMP
`define DATAOP_CMP 4'hA
`endif

module alu_arbiter #(
    parameter int DATA_WIDTH = `BIT_WIDTH
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  dp_req_valid,
    output logic                  dp_req_ready,
    input  logic [3:0]            dp_op,
    input  logic [DATA_WIDTH-1:0] dp_a,
    input  logic [DATA_WIDTH-1:0] dp_b,
    input  logic [3:0]            dp_cond,
    input  logic                  dp_set_flags,
    output logic                  dp_rsp_valid,
    input  logic                  dp_rsp_ready,
    output logic [DATA_WIDTH-1:0] dp_rsp_result,
    output logic                  dp_rsp_executed,
    output logic                  dp_rsp_write_rd,
    input  logic                  mem_req_valid,
    output logic                  mem_req_ready,
    input  logic [DATA_WIDTH-1:0] mem_base,
    input  logic [DATA_WIDTH-1:0] mem_offset,
    input  logic                  mem_up,
    output logic                  mem_rsp_valid,
    input  logic                  mem_rsp_ready,
    output logic [DATA_WIDTH-1:0] mem_rsp_addr,
    output logic [3:0]            alu_op,
    output logic [DATA_WIDTH-1:0] alu_a,
    output logic [DATA_WIDTH-1:0] alu_b,
    input  logic [DATA_WIDTH:0]   alu_result,
    input  logic                  alu_n,
    input  logic                  alu_z,
    input  logic                  alu_c,
    input  logic                  alu_v,
    output logic [3:0]            flags_nzcv,
    output logic                  busy
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_EXEC,
        S_RESP
    } state_t;

    state_t     state;
    logic       last_grant_mem;
    logic       owner_mem;
    logic [3:0] lat_cond;
    logic       lat_set_flags;

    logic grant_dp;
    logic grant_mem;
    logic pass;
    logic is_test_op;
    logic alu_result_unused;

    assign alu_result_unused = alu_result[DATA_WIDTH];

    // Round-robin: on a tie the port that did not win last time is granted.
    assign grant_dp      = dp_req_valid  & (~mem_req_valid | last_grant_mem);
    assign grant_mem     = mem_req_valid & (~dp_req_valid  | ~last_grant_mem);
    assign dp_req_ready  = (state == S_IDLE) & grant_dp;
    assign mem_req_ready = (state == S_IDLE) & grant_mem;
    assign busy          = (state != S_IDLE);

    function automatic logic cond_eval(input logic [3:0] cond, input logic [3:0] f);
        logic n, z, c, v;
        {n, z, c, v} = f;
        case (cond)
            4'h0:    cond_eval = z;
            4'h1:    cond_eval = ~z;
            4'h2:    cond_eval = c;
            4'h3:    cond_eval = ~c;
            4'h4:    cond_eval = n;
            4'h5:    cond_eval = ~n;
            4'h6:    cond_eval = v;
            4'h7:    cond_eval = ~v;
            4'h8:    cond_eval = c & ~z;
            4'h9:    cond_eval = ~c | z;
            4'hA:    cond_eval = (n == v);
            4'hB:    cond_eval = (n != v);
            4'hC:    cond_eval = ~z & (n == v);
            4'hD:    cond_eval = z | (n != v);
            default: cond_eval = 1'b1;
        endcase
    endfunction

    // alu_op still holds the latched DP opcode throughout EXEC.
    assign pass       = cond_eval(lat_cond, flags_nzcv);
    assign is_test_op = (alu_op == `DATAOP_TST) || (alu_op == `DATAOP_TEQ) ||
                        (alu_op == `DATAOP_CMP);

    always_ff @(posedge clk) begin
        if (reset) begin
            state           <= S_IDLE;
            last_grant_mem  <= 1'b1;
            owner_mem       <= 1'b0;
            lat_cond        <= 4'h0;
            lat_set_flags   <= 1'b0;
            flags_nzcv      <= 4'h0;
            dp_rsp_valid    <= 1'b0;
            dp_rsp_result   <= '0;
            dp_rsp_executed <= 1'b0;
            dp_rsp_write_rd <= 1'b0;
            mem_rsp_valid   <= 1'b0;
            mem_rsp_addr    <= '0;
            alu_op          <= 4'h0;
            alu_a           <= '0;
            alu_b           <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (dp_req_ready) begin
                        owner_mem      <= 1'b0;
                        last_grant_mem <= 1'b0;
                        lat_cond       <= dp_cond;
                        lat_set_flags  <= dp_set_flags;
                        alu_op         <= dp_op;
                        alu_a          <= dp_a;
                        alu_b          <= dp_b;
                        state          <= S_EXEC;
                    end else if (mem_req_ready) begin
                        owner_mem      <= 1'b1;
                        last_grant_mem <= 1'b1;
                        alu_op         <= mem_up ? `DATAOP_ADD : `DATAOP_SUB;
                        alu_a          <= mem_base;
                        alu_b          <= mem_offset;
                        state          <= S_EXEC;
                    end
                end
                S_EXEC: begin
                    if (owner_mem) begin
                        mem_rsp_addr  <= alu_result[DATA_WIDTH-1:0];
                        mem_rsp_valid <= 1'b1;
                    end else begin
                        dp_rsp_valid <= 1'b1;
                        if (pass) begin
                            dp_rsp_result   <= alu_result[DATA_WIDTH-1:0];
                            dp_rsp_executed <= 1'b1;
                            dp_rsp_write_rd <= ~is_test_op;
                            if (lat_set_flags || is_test_op)
                                flags_nzcv <= {alu_n, alu_z, alu_c, alu_v};
                        end else begin
                            dp_rsp_result   <= '0;
                            dp_rsp_executed <= 1'b0;
                            dp_rsp_write_rd <= 1'b0;
                        end
                    end
                    alu_op <= 4'h0;
                    alu_a  <= '0;
                    alu_b  <= '0;
                    state  <= S_RESP;
                end
                S_RESP: begin
                    if (owner_mem && mem_rsp_ready) begin
                        mem_rsp_valid <= 1'b0;
                        state         <= S_IDLE;
                    end else if (!owner_mem && dp_rsp_ready) begin
                        dp_rsp_valid <= 1'b0;
                        state        <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_arbiter.sv
// tb/tb_alu_arbiter.sv - directed self-checking bench for alu_arbiter with a small ALU model
module tb_alu_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic        dp_req_valid, dp_req_ready;
    logic [3:0]  dp_op, dp_cond;
    logic [31:0] dp_a, dp_b;
    logic        dp_set_flags;
    logic        dp_rsp_valid, dp_rsp_ready;
    logic [31:0] dp_rsp_result;
    logic        dp_rsp_executed, dp_rsp_write_rd;
    logic        mem_req_valid, mem_req_ready;
    logic [31:0] mem_base, mem_offset;
    logic        mem_up;
    logic        mem_rsp_valid, mem_rsp_ready;
    logic [31:0] mem_rsp_addr;
    logic [3:0]  alu_op;
    logic [31:0] alu_a, alu_b;
    logic [32:0] alu_result;
    logic        alu_n, alu_z, alu_c, alu_v;
    logic [3:0]  flags_nzcv;
    logic        busy;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    alu_arbiter #(.DATA_WIDTH(32)) dut (
        .clk(clk), .reset(reset),
        .dp_req_valid(dp_req_valid), .dp_req_ready(dp_req_ready),
        .dp_op(dp_op), .dp_a(dp_a), .dp_b(dp_b), .dp_cond(dp_cond),
        .dp_set_flags(dp_set_flags),
        .dp_rsp_valid(dp_rsp_valid), .dp_rsp_ready(dp_rsp_ready),
        .dp_rsp_result(dp_rsp_result), .dp_rsp_executed(dp_rsp_executed),
        .dp_rsp_write_rd(dp_rsp_write_rd),
        .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready),
        .mem_base(mem_base), .mem_offset(mem_offset), .mem_up(mem_up),
        .mem_rsp_valid(mem_rsp_valid), .mem_rsp_ready(mem_rsp_ready),
        .mem_rsp_addr(mem_rsp_addr),
        .alu_op(alu_op), .alu_a(alu_a), .alu_b(alu_b), .alu_result(alu_result),
        .alu_n(alu_n), .alu_z(alu_z), .alu_c(alu_c), .alu_v(alu_v),
        .flags_nzcv(flags_nzcv), .busy(busy)
    );

    // ALU model: ADD (4), SUB (2), CMP (A); carry is "no borrow" for subtraction.
    always_comb begin
        alu_result = 33'd0;
        alu_c      = 1'b0;
        alu_v      = 1'b0;
        case (alu_op)
            4'h4: begin
                alu_result = {1'b0, alu_a} + {1'b0, alu_b};
                alu_c      = alu_result[32];
                alu_v      = (alu_a[31] == alu_b[31]) && (alu_result[31] != alu_a[31]);
            end
            4'h2, 4'hA: begin
                alu_result = {1'b0, alu_a} - {1'b0, alu_b};
                alu_c      = ~alu_result[32];
                alu_v      = (alu_a[31] != alu_b[31]) && (alu_result[31] != alu_a[31]);
            end
            default: alu_result = 33'd0;
        endcase
        alu_n = alu_result[31];
        alu_z = (alu_result[31:0] == 32'd0);
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset = 1'b1;
        dp_req_valid = 0; dp_op = 0; dp_a = 0; dp_b = 0; dp_cond = 0; dp_set_flags = 0;
        dp_rsp_ready = 1;
        mem_req_valid = 0; mem_base = 0; mem_offset = 0; mem_up = 0;
        mem_rsp_ready = 1;
        tick();
        tick();
        reset = 1'b0;
        chk("reset_flags", flags_nzcv, 4'h0);
        chk("reset_dp_rsp_valid", dp_rsp_valid, 1'b0);
        chk("reset_mem_rsp_valid", mem_rsp_valid, 1'b0);
        chk("reset_busy", busy, 1'b0);
        chk("reset_alu_op", alu_op, 4'h0);

        // Both request: DP SUB 5-5 S=1 AL, MEM 0x100-0x4.
        dp_req_valid = 1; dp_op = 4'h2; dp_a = 5; dp_b = 5; dp_cond = 4'hE; dp_set_flags = 1;
        mem_req_valid = 1; mem_base = 32'h100; mem_offset = 32'h4; mem_up = 0;
        #1;
        chk("first_tie_dp_ready", dp_req_ready, 1'b1);
        chk("first_tie_mem_ready", mem_req_ready, 1'b0);

        tick();  // accepted; now EXEC
        chk("exec_alu_op_sub", alu_op, 4'h2);
        chk("exec_alu_a", alu_a, 32'd5);
        chk("exec_alu_b", alu_b, 32'd5);
        chk("exec_busy", busy, 1'b1);
        chk("exec_dp_ready", dp_req_ready, 1'b0);
        chk("exec_mem_ready", mem_req_ready, 1'b0);
        dp_op = 4'h4; dp_a = 1; dp_b = 2; dp_cond = 4'h0; dp_set_flags = 0;

        tick();  // RESP
        chk("sub_rsp_valid", dp_rsp_valid, 1'b1);
        chk("sub_result", dp_rsp_result, 32'd0);
        chk("sub_executed", dp_rsp_executed, 1'b1);
        chk("sub_write_rd", dp_rsp_write_rd, 1'b1);
        chk("sub_flags", flags_nzcv, 4'b0110);
        chk("resp_alu_op_zero", alu_op, 4'h0);
        chk("resp_mem_rsp_valid", mem_rsp_valid, 1'b0);

        tick();  // handshake done, IDLE
        chk("sub_rsp_drop", dp_rsp_valid, 1'b0);
        chk("idle_busy", busy, 1'b0);
        chk("rr_mem_ready", mem_req_ready, 1'b1);
        chk("rr_dp_not_ready", dp_req_ready, 1'b0);

        tick();  // MEM accepted, EXEC
        chk("mem_alu_op_sub", alu_op, 4'h2);
        chk("mem_alu_a", alu_a, 32'h100);
        chk("mem_alu_b", alu_b, 32'h4);

        tick();  // MEM RESP
        chk("mem_rsp_valid", mem_rsp_valid, 1'b1);
        chk("mem_addr", mem_rsp_addr, 32'hFC);
        chk("mem_dp_rsp_quiet", dp_rsp_valid, 1'b0);
        chk("mem_flags_unchanged", flags_nzcv, 4'b0110);

        tick();  // IDLE
        chk("mem_rsp_drop", mem_rsp_valid, 1'b0);
        chk("rr_dp_ready", dp_req_ready, 1'b1);
        chk("rr_mem_not_ready", mem_req_ready, 1'b0);

        tick();  // DP ADD EQ accepted, EXEC
        chk("add_alu_op", alu_op, 4'h4);
        dp_rsp_ready = 0;
        dp_cond = 4'h1;

        tick();  // RESP, backpressured
        chk("eq_rsp_valid", dp_rsp_valid, 1'b1);
        chk("eq_result", dp_rsp_result, 32'd3);
        chk("eq_executed", dp_rsp_executed, 1'b1);
        chk("eq_write_rd", dp_rsp_write_rd, 1'b1);
        chk("eq_flags_nos", flags_nzcv, 4'b0110);
        for (int i = 0; i < 2; i++) begin
            tick();
            chk("bp_valid", dp_rsp_valid, 1'b1);
            chk("bp_result", dp_rsp_result, 32'd3);
            chk("bp_executed", dp_rsp_executed, 1'b1);
            chk("bp_dp_ready", dp_req_ready, 1'b0);
            chk("bp_mem_ready", mem_req_ready, 1'b0);
        end
        dp_rsp_ready = 1;
        #1;
        chk("bp_mem_ready_at_hs", mem_req_ready, 1'b0);

        tick();  // handshake done
        chk("bp_rsp_drop", dp_rsp_valid, 1'b0);
        chk("bp_mem_ready_after", mem_req_ready, 1'b1);

        tick();  // MEM accepted
        mem_req_valid = 0;
        tick();
        chk("mem2_addr", mem_rsp_addr, 32'hFC);
        tick();
        chk("ne_dp_ready", dp_req_ready, 1'b1);

        tick();  // DP ADD NE accepted
        dp_req_valid = 0;
        tick();
        chk("ne_rsp_valid", dp_rsp_valid, 1'b1);
        chk("ne_executed", dp_rsp_executed, 1'b0);
        chk("ne_write_rd", dp_rsp_write_rd, 1'b0);
        chk("ne_result", dp_rsp_result, 32'd0);
        chk("ne_flags", flags_nzcv, 4'b0110);
        tick();
        chk("ne_idle", busy, 1'b0);

        // CMP 1 vs 2, reset lands in EXEC.
        dp_req_valid = 1; dp_op = 4'hA; dp_a = 1; dp_b = 2; dp_cond = 4'hE; dp_set_flags = 0;
        tick();
        dp_req_valid = 0;
        chk("cmp_exec_busy", busy, 1'b1);
        reset = 1;
        tick();
        reset = 0;
        chk("rst_mid_dp_rsp", dp_rsp_valid, 1'b0);
        chk("rst_mid_flags", flags_nzcv, 4'h0);
        chk("rst_mid_busy", busy, 1'b0);
        tick();
        chk("rst_after_dp_rsp", dp_rsp_valid, 1'b0);
        chk("rst_after_flags", flags_nzcv, 4'h0);
        chk("rst_after_busy", busy, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
